// File: rtl/cntrl_seq_param_pkg.sv
// rtl/cntrl_seq_param_pkg.sv - state encoding and default sizing for the MAC sequencer
package cntrl_seq_pkg;

  localparam int DEF_N_TAPS = 16;
  localparam int DEF_N_CH   = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_MAC   = 3'd3,
    ST_WR_Y  = 3'd4,
    ST_WR_U  = 3'd5,
    ST_SHIFT = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/cntrl_seq_param_if.sv
// rtl/cntrl_seq_param_if.sv - control/strobe bundle between sequencer and datapath (CNTRL_SEQ_PARAM_ERR_EN adds err)
interface cntrl_seq_param_if #(
  parameter int SEL_W = 4,
  parameter int CH_W  = 1
);
  logic             inicio;
  logic             cambiar;
  logic             leer;
  logic             rst_acum;
  logic [SEL_W-1:0] sel;
  logic             leer_y;
  logic             leer_u;
  logic             desp;
  logic [CH_W-1:0]  canal;
  logic             ocupado;
  logic             listo;
`ifdef CNTRL_SEQ_PARAM_ERR_EN
  logic             err;
`endif

  modport master (
    output inicio, cambiar,
`ifdef CNTRL_SEQ_PARAM_ERR_EN
    input  err,
`endif
    input  leer, rst_acum, sel, leer_y, leer_u, desp, canal, ocupado, listo
  );

  modport slave (
    input  inicio, cambiar,
`ifdef CNTRL_SEQ_PARAM_ERR_EN
    output err,
`endif
    output leer, rst_acum, sel, leer_y, leer_u, desp, canal, ocupado, listo
  );

endinterface

// File: rtl/cntrl_seq_param_cnt.sv
// rtl/cntrl_seq_param_cnt.sv - modulo-LIMIT up counter with clear, enable and terminal-count flag
module cntrl_seq_cnt #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // Terminal count at LIMIT-1 so the value never leaves 0..LIMIT-1
  assign tc = (q == WIDTH'(LIMIT - 1));

  // Count register: clear wins over enable, wrap to zero after terminal count
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= tc ? '0 : q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cntrl_seq_param.sv
// rtl/cntrl_seq_param.sv - multi-channel MAC sequencer top (optional err output under CNTRL_SEQ_PARAM_ERR_EN)
module cntrl_seq_param
  import cntrl_seq_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int N_CH   = DEF_N_CH,
  parameter int SEL_W  = $clog2(N_TAPS),
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic               clk,
  input logic               rst,
  cntrl_seq_param_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] tap_q;
  logic             tap_tc;
  logic [CH_W-1:0]  ch_q;
  logic             ch_tc;

  // Tap index runs only inside MAC and is held at zero elsewhere
  cntrl_seq_cnt #(.WIDTH(SEL_W), .LIMIT(N_TAPS)) u_tap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_MAC),
    .en  (state_q == ST_MAC),
    .q   (tap_q),
    .tc  (tap_tc)
  );

  // Channel index restarts from zero whenever a new frame can begin
  cntrl_seq_cnt #(.WIDTH(CH_W), .LIMIT(N_CH)) u_ch_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((state_q == ST_IDLE) || (state_q == ST_DONE)),
    .en  ((state_q == ST_SHIFT) && !ch_tc),
    .q   (ch_q),
    .tc  (ch_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore output decode from the state register
  always_comb begin
    state_d      = state_q;
    bus.leer     = 1'b0;
    bus.rst_acum = 1'b0;
    bus.leer_y   = 1'b0;
    bus.leer_u   = 1'b0;
    bus.desp     = 1'b0;
    bus.listo    = 1'b0;
    bus.ocupado  = (state_q != ST_IDLE);
    bus.sel      = (state_q == ST_MAC) ? tap_q : '0;
    bus.canal    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.inicio) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bus.leer = 1'b1;
        state_d  = ST_CLR;
      end
      ST_CLR: begin
        bus.rst_acum = 1'b1;
        state_d      = ST_MAC;
      end
      ST_MAC: begin
        if (tap_tc) state_d = ST_WR_Y;
      end
      ST_WR_Y: begin
        bus.leer_y = 1'b1;
        state_d    = ST_WR_U;
      end
      ST_WR_U: begin
        bus.leer_u = 1'b1;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        bus.desp = 1'b1;
        state_d  = ch_tc ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        bus.listo = 1'b1;
        state_d   = bus.cambiar ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CNTRL_SEQ_PARAM_ERR_EN
  // Sticky flag for a start request that arrived while a frame was running
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err <= 1'b0;
    end else if (bus.inicio && (state_q != ST_IDLE)) begin
      bus.err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cntrl_seq_param.sv
// tb/tb_cntrl_seq_param.sv - directed bench for cntrl_seq_param (checks err when CNTRL_SEQ_PARAM_ERR_EN is defined)
module tb_cntrl_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   listo1_cnt;
  int   listo3_cnt;

  always #5 clk = ~clk;

  cntrl_seq_param_if #(.SEL_W(2), .CH_W(1)) if1 ();
  cntrl_seq_param_if #(.SEL_W(2), .CH_W(2)) if3 ();
  cntrl_seq_param_if #(.SEL_W(3), .CH_W(1)) if5 ();

  cntrl_seq_param #(.N_TAPS(4), .N_CH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  cntrl_seq_param #(.N_TAPS(4), .N_CH(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  cntrl_seq_param #(.N_TAPS(5), .N_CH(2)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  // {leer, rst_acum, leer_y, leer_u, desp, listo, ocupado, sel[7:0], canal[3:0]}
  logic [18:0] obs1, obs3, obs5;
  assign obs1 = {if1.leer, if1.rst_acum, if1.leer_y, if1.leer_u, if1.desp, if1.listo,
                 if1.ocupado, 8'(if1.sel), 4'(if1.canal)};
  assign obs3 = {if3.leer, if3.rst_acum, if3.leer_y, if3.leer_u, if3.desp, if3.listo,
                 if3.ocupado, 8'(if3.sel), 4'(if3.canal)};
  assign obs5 = {if5.leer, if5.rst_acum, if5.leer_y, if5.leer_u, if5.desp, if5.listo,
                 if5.ocupado, 8'(if5.sel), 4'(if5.canal)};

  // Expected output word k cycles after inicio was sampled (k=0 or past the frame: idle)
  function automatic logic [18:0] model(int k, int nt, int nc);
    int p = nt + 5;
    int j;
    int ch;
    logic [18:0] r = '0;
    if (k >= 1 && k <= nc * p) begin
      j = (k - 1) % p;
      ch = (k - 1) / p;
      r[12] = 1'b1;
      r[3:0] = 4'(ch);
      if (j == 0) r[18] = 1'b1;
      else if (j == 1) r[17] = 1'b1;
      else if (j <= nt + 1) r[11:4] = 8'(j - 2);
      else if (j == nt + 2) r[16] = 1'b1;
      else if (j == nt + 3) r[15] = 1'b1;
      else r[14] = 1'b1;
    end else if (k == nc * p + 1) begin
      r[13] = 1'b1;
      r[12] = 1'b1;
      r[3:0] = 4'(nc - 1);
    end
    return r;
  endfunction

  task automatic chk(string tag, int k, logic [18:0] obs, logic [18:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic i, logic c);
    if1.inicio = i; if3.inicio = i; if5.inicio = i;
    if1.cambiar = c; if3.cambiar = c; if5.cambiar = c;
  endtask

  task automatic check_all(string tag, int k1, int k3, int k5);
    chk({tag, "_d1"}, k1, obs1, model(k1, 4, 1));
    chk({tag, "_d3"}, k3, obs3, model(k3, 4, 3));
    chk({tag, "_d5"}, k5, obs5, model(k5, 5, 2));
    chk({tag, "_excl3"}, k3, 19'($countones(obs3[18:14]) <= 1), 19'd1);
    chk({tag, "_sel5"}, k5, 19'(obs5[11:4] <= 8'd4), 19'd1);
  endtask

  initial begin
    drive(1'b0, 1'b0);
    // Reset state
    step();
    step();
    check_all("reset", 0, 0, 0);
    rst = 1'b0;

    // Single-shot frame on all three configurations
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0);
    chk("single_leer_first", 1, 19'(if1.leer), 19'd1);
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) step();
      check_all("single", k, k, k);
      if (k == 10) chk("single_listo_at_10", k, 19'(if1.listo), 19'd1);
      if (k == 28) chk("single_listo_at_28", k, 19'(if3.listo), 19'd1);
    end

    // Free-run: d1 restarts once, cambiar dropped mid-frame; d3/d5 see cambiar=0 at their DONE
    drive(1'b1, 1'b1);
    step();
    drive(1'b0, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) step();
      check_all("freerun", (k > 10) ? k - 10 : k, k, k);
      if (k == 11) chk("freerun_reload", k, {18'd0, if1.leer}, 19'd1);
      if (k == 13) drive(1'b0, 1'b0);
    end

    // Reset during MAC at sel=2 with a coincident inicio
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      check_all("prerst", k, k, k);
    end
    chk("prerst_sel2", 5, 19'(if1.sel), 19'd2);
    rst = 1'b1;
    drive(1'b1, 1'b0);
    step();
    check_all("inrst", 0, 0, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0);
    step();
    check_all("postrst", 0, 0, 0);
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) step();
      check_all("restart", k, k, k);
    end
`ifdef CNTRL_SEQ_PARAM_ERR_EN
    chk("err_clean", 0, {16'd0, if1.err, if3.err, if5.err}, 19'd0);
`endif

    // Start requests while busy are dropped
    listo1_cnt = 0;
    listo3_cnt = 0;
    drive(1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) step();
      check_all("busy", k, k, k);
      listo1_cnt += int'(if1.listo);
      listo3_cnt += int'(if3.listo);
      if (k == 3 || k == 5) drive(1'b1, 1'b0);
      else drive(1'b0, 1'b0);
    end
    chk("busy_listo1_once", 0, 19'(listo1_cnt), 19'd1);
    chk("busy_listo3_once", 0, 19'(listo3_cnt), 19'd1);
`ifdef CNTRL_SEQ_PARAM_ERR_EN
    chk("err_set", 0, {16'd0, if1.err, if3.err, if5.err}, 19'b111);
    step();
    chk("err_sticky", 0, {16'd0, if1.err, if3.err, if5.err}, 19'b111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", 0, {16'd0, if1.err, if3.err, if5.err}, 19'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cntrl_seq_param.md
CNTRL_SEQ_PARAM -- requirements
Module: cntrl_seq_param

Interface
REQ-001 SHALL provide parameter N_TAPS, default 16, number of coefficient/tap steps per sample (range 2..256).
REQ-002 SHALL provide parameter N_CH, default 1, number of channels processed per frame (range 1..16).
REQ-003 SHALL provide parameter SEL_W, default $clog2(N_TAPS), width of sel.
REQ-004 SHALL provide parameter CH_W, default max(1,$clog2(N_CH)), width of canal.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 inicio  input  1  start request for one frame (all channels).
REQ-008 cambiar  input  1  mode: 1 = free-run (frames restart automatically), 0 = single-shot.
REQ-009 leer  output  1  one-cycle strobe: load input sample of current channel.
REQ-010 rst_acum  output  1  one-cycle strobe: clear accumulator.
REQ-011 sel  output  SEL_W  tap/coefficient index during MAC phase, 0 otherwise.
REQ-012 leer_y  output  1  one-cycle strobe: latch accumulator result y.
REQ-013 leer_u  output  1  one-cycle strobe: latch output register u.
REQ-014 desp  output  1  one-cycle strobe: shift delay line of current channel.
REQ-015 canal  output  CH_W  index of channel being processed.
REQ-016 ocupado  output  1  high in every state except IDLE.
REQ-017 listo  output  1  one-cycle pulse at frame completion.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, CLR, MAC, WR_Y, WR_U, SHIFT, DONE; all outputs registered (Moore, decoded from state register).
REQ-019 IDLE: inicio=1 -> LOAD with canal=0; otherwise remain.
REQ-020 LOAD (leer=1) -> CLR (rst_acum=1) -> MAC, each one cycle.
REQ-021 MAC SHALL last exactly N_TAPS cycles, sel=0,1,...,N_TAPS-1, then -> WR_Y.
REQ-022 WR_Y (leer_y=1) -> WR_U (leer_u=1) -> SHIFT (desp=1), each one cycle.
REQ-023 SHIFT: canal<N_CH-1 -> canal+1, LOAD; canal=N_CH-1 -> DONE.
REQ-024 Per-channel latency SHALL be N_TAPS+5 cycles; frame latency inicio-to-listo N_CH*(N_TAPS+5)+1 cycles.
REQ-025 DONE (listo=1, one cycle): cambiar=1 -> LOAD, canal=0; cambiar=0 -> IDLE.
REQ-026 cambiar SHALL be sampled only in DONE; changes elsewhere have no effect on the current frame.
REQ-027 inicio while ocupado=1 SHALL be ignored (no queuing).
REQ-028 At most one strobe among leer, rst_acum, leer_y, leer_u, desp SHALL be high in any cycle.
REQ-029 sel SHALL never exceed N_TAPS-1; canal never exceed N_CH-1 (no wrap outside range when N_TAPS/N_CH not power of two).

Reset
REQ-030 rst=1 at any clock edge, including mid-frame, SHALL force IDLE, sel=0, canal=0, all strobes, ocupado, listo =0 on the next cycle.
REQ-031 inicio coincident with rst SHALL be ignored.

Configuration
REQ-032 Macro CNTRL_SEQ_PARAM_ERR_EN defined: extra output err (1 bit), sticky, set when inicio=1 while ocupado=1, cleared only by rst.
REQ-033 Macro undefined: no err port; ignored inicio leaves no trace.

Structure
REQ-034 Package cntrl_seq_pkg SHALL hold the state encoding (3-bit, named constants) and default N_TAPS/N_CH constants.
REQ-035 Tap and channel counters SHALL use one sub-module cntrl_seq_cnt (parametrised width/limit, clear, enable, terminal-count flag), instantiated twice.

Verification
REQ-036 N_TAPS=4, N_CH=1, cambiar=0: inicio pulse -> leer, rst_acum, sel 0..3, leer_y, leer_u, desp, listo on consecutive cycles; listo 10 cycles after inicio; then IDLE.
REQ-037 N_TAPS=4, N_CH=3: canal steps 0,1,2; listo 28 cycles after inicio; strobes mutually exclusive every cycle.
REQ-038 cambiar=1: after listo, leer asserted next cycle with canal=0; drop cambiar mid-frame -> frame completes, one more listo, then IDLE.
REQ-039 rst asserted during MAC at sel=2 -> next cycle IDLE, all outputs 0; new inicio restarts at canal=0, sel=0.
REQ-040 inicio pulses at cycles 3 and 5 after start -> ignored, single listo; with CNTRL_SEQ_PARAM_ERR_EN err=1 until rst.
REQ-041 N_TAPS=5 (non power of two): sel reaches 4 then 0; never 5..7.
